alu_seq_arbiter: RTL
====================

ALU_SEQ_ARBITER -- requirements
Module: alu_seq_arbiter

Interface
REQ-001 Parameter DATA_W, default 16, operand/result width driven to and captured from the ALU.
REQ-002 Parameter CMD_W, default 3, ALU command width.
REQ-003 Parameter CNT_W, default 4, repeat-count width.
REQ-004 CLK  input  1  single clock; all state updates on rising edge.
REQ-005 RST  input  1  reset, synchronous, active-high.
REQ-006 REQ0_VALID, REQ1_VALID  input  1  requester n has an operation pending.
REQ-007 REQ0_READY, REQ1_READY  output  1  requester n's operation is accepted this cycle.
REQ-008 REQ0_DATA, REQ1_DATA  input  DATA_W  initial operand.
REQ-009 REQ0_CMD, REQ1_CMD  input  CMD_W  ALU command.
REQ-010 REQ0_CNT, REQ1_CNT  input  CNT_W  repeat count k; the operation runs k+1 passes.
REQ-011 ALU_OPND  output  DATA_W  operand to the ALU.
REQ-012 ALU_CMD  output  CMD_W  command to the ALU.
REQ-013 ALU_RES  input  DATA_W  combinational ALU result.
REQ-014 RSP_VALID  output  1  a response is available.
REQ-015 RSP_READY  input  1  the consumer takes the response.
REQ-016 RSP_DATA  output  DATA_W  final result.
REQ-017 RSP_ID  output  1  index of the requester that owns the response.
REQ-018 RSP_ERR  output  1  the command was illegal (101 or 110).

Function
REQ-019 The controller SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-020 In IDLE with any REQn_VALID high, it SHALL grant exactly one requester.
- Grant is round-robin; the priority pointer starts at 0.
- REQn_READY is asserted combinationally in that cycle for the granted requester only.
- DATA, CMD, CNT and the ID are latched, and the state goes to EXEC.
REQ-021 With both requests valid, the requester selected by the pointer SHALL win.
- The other requester's READY stays low; it is granted on the next IDLE cycle.
REQ-022 The pointer SHALL move to the non-winning requester on each handshake, i.e. when RSP_VALID and RSP_READY are both high.
REQ-023 In EXEC, ALU_OPND SHALL equal the operand register and ALU_CMD SHALL equal the latched command.
- Each cycle, ALU_RES is written back into the operand register.
- If the remaining count is 0, the state goes to RESP; otherwise the count decrements and the state stays in EXEC.
REQ-024 Latency SHALL be k+2 cycles from the accept edge to RSP_VALID high: k+1 EXEC cycles, then RESP.
REQ-025 A latched command of 101 or 110 SHALL drive ALU_CMD = 111 (NOP) for every pass and set RSP_ERR = 1.
- All legal commands drive RSP_ERR = 0.
REQ-026 In RESP, RSP_VALID SHALL be 1 while RSP_DATA, RSP_ID and RSP_ERR stay stable until RSP_READY is high.
- The state then returns to IDLE.
- No new request is accepted during the same cycle.
REQ-027 Outside EXEC, ALU_OPND SHALL be 0 and ALU_CMD SHALL be 111.
REQ-028 Arithmetic wrap-around SHALL be carried through unchanged.
- The controller neither saturates nor extends width.
- Reduction results are captured as the full DATA_W ALU_RES.
REQ-029 REQn_READY SHALL be 0 in EXEC and RESP, whatever REQn_VALID is.

Reset
REQ-030 On RST, the outputs and state SHALL be:
- state = IDLE, pointer = 0;
- RSP_VALID = 0, RSP_DATA = 0, RSP_ID = 0, RSP_ERR = 0;
- REQ0_READY = REQ1_READY = 0;
- ALU_OPND = 0, ALU_CMD = 111.
REQ-031 RST asserted in EXEC or RESP SHALL discard the operation in flight without producing a response.
REQ-032 RST SHALL take priority over every other event in the same cycle.

Configuration
REQ-033 Macro ALU_SEQ_REPEAT_EN SHALL control the repeat count.
- Defined: REQn_CNT is honoured as in REQ-023 and REQ-024.
- Undefined: REQn_CNT is ignored and k = 0, giving one pass and a latency of 2.
- Undefined: no count register is built.

Structure
REQ-034 The shared package alu_pkg SHALL hold:
- command localparams INC=000, DEC=001, INV=010, REDAND=011, REDOR=100, TEMP0=101, TEMP1=110, NOP=111;
- the state enum {IDLE, EXEC, RESP};
- default widths 16, 3 and 4.
REQ-035 The two-requester round-robin grant logic SHALL be a sub-module alu_rr_arb.
- Inputs: valids, pointer and enable.
- Outputs: one-hot grant.

Verification
REQ-036 Reset, then REQ0 = {0xFFFF, INC, k=0} -> ALU_CMD = 000 for one cycle; RSP = {0x0000, ID=0, ERR=0} 2 cycles after accept.
REQ-037 REQ1 = {0x0005, DEC, k=3} -> 4 EXEC cycles; RSP_DATA = 0x0001, ID=1, latency 5.
REQ-038 Both valid with pointer 0, both cmd INV, k=1 -> REQ0 granted first, returns 0x1234 from 0x1234; then REQ1 is granted and the pointer ends at 0.
REQ-039 REQ0 cmd = 110, DATA = 0x00A5 -> ALU_CMD = 111; RSP = {0x00A5, ERR=1}.
REQ-040 Hold RSP_READY = 0 for 3 cycles -> RSP fields stable and both READYs 0 throughout; RST pulse during EXEC -> no RSP_VALID, all outputs at reset values next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequenced ALU arbiter:
// ALU command codes, controller state encoding and default widths.
package alu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int CMD_W_DEF  = 3;
    localparam int CNT_W_DEF  = 4;

    localparam logic [2:0] INC    = 3'b000;
    localparam logic [2:0] DEC    = 3'b001;
    localparam logic [2:0] INV    = 3'b010;
    localparam logic [2:0] REDAND = 3'b011;
    localparam logic [2:0] REDOR  = 3'b100;
    localparam logic [2:0] TEMP0  = 3'b101;
    localparam logic [2:0] TEMP1  = 3'b110;
    localparam logic [2:0] NOP    = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_rr_arb.sv
// alu_rr_arb -- two-requester round-robin grant. The requester named by
// ptr wins a tie; the grant is one-hot and forced to zero when en is low.
module alu_rr_arb (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       en,
    output logic [1:0] grant
);

    // Pick the pointed-to requester first, otherwise the other one
    always_comb begin
        grant = 2'b00;
        if (en) begin
            if (!ptr) begin
                if (valid[0])      grant = 2'b01;
                else if (valid[1]) grant = 2'b10;
            end else begin
                if (valid[1])      grant = 2'b10;
                else if (valid[0]) grant = 2'b01;
            end
        end
    end

endmodule

// File: rtl/alu_seq_arbiter.sv
// alu_seq_arbiter -- arbitrates two requesters onto one combinational ALU
// and iterates the granted operation k+1 times, feeding each result back
// as the next operand, then presents the final value as a response.
// Build option: ALU_SEQ_REPEAT_EN. When defined the per-request repeat
// count is honoured; when undefined every operation is a single pass and
// no count register exists.
module alu_seq_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CMD_W  = CMD_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              REQ0_VALID,
    input  logic              REQ1_VALID,
    output logic              REQ0_READY,
    output logic              REQ1_READY,
    input  logic [DATA_W-1:0] REQ0_DATA,
    input  logic [DATA_W-1:0] REQ1_DATA,
    input  logic [CMD_W-1:0]  REQ0_CMD,
    input  logic [CMD_W-1:0]  REQ1_CMD,
    input  logic [CNT_W-1:0]  REQ0_CNT,
    input  logic [CNT_W-1:0]  REQ1_CNT,
    output logic [DATA_W-1:0] ALU_OPND,
    output logic [CMD_W-1:0]  ALU_CMD,
    input  logic [DATA_W-1:0] ALU_RES,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              RSP_ID,
    output logic              RSP_ERR
);

    state_t              state;
    state_t              state_nx;
    logic                ptr;
    logic [1:0]          grant;
    logic                arb_en;
    logic                accept;
    logic                last_pass;
    logic                handshake;

    logic [DATA_W-1:0]   opnd;
    logic [CMD_W-1:0]    cmd_r;
    logic                id_r;
    logic                err_r;

    // Reserved command codes run as NOP and flag the response.
    function automatic logic cmd_illegal(input logic [CMD_W-1:0] c);
        return (c == CMD_W'(TEMP0)) || (c == CMD_W'(TEMP1));
    endfunction

    // Grants are only offered from IDLE; reset suppresses them outright.
    assign arb_en    = (state == IDLE) && !RST;
    assign accept    = |grant;
    assign handshake = (state == RESP) && RSP_READY;

    alu_rr_arb u_arb (
        .valid (({REQ1_VALID, REQ0_VALID})),
        .ptr   (ptr),
        .en    (arb_en),
        .grant (grant)
    );

`ifdef ALU_SEQ_REPEAT_EN
    logic [CNT_W-1:0] cnt;

    assign last_pass = (cnt == '0);

    // Remaining-pass counter: loaded on accept, counts down each EXEC cycle
    always_ff @(posedge CLK) begin
        if (accept) begin
            cnt <= grant[1] ? REQ1_CNT : REQ0_CNT;
        end else if ((state == EXEC) && !last_pass) begin
            cnt <= cnt - CNT_W'(1);
        end
    end
`else
    logic unused_cnt;

    // Counts are not used in the single-pass build.
    assign unused_cnt = ^{REQ0_CNT, REQ1_CNT};
    assign last_pass  = 1'b1;
`endif

    // Control state and round-robin pointer; reset wins over everything
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= 1'b0;
        end else begin
            state <= state_nx;
            if (handshake) begin
                ptr <= ~id_r;
            end
        end
    end

    // Operand capture on accept, then ALU write-back every EXEC cycle
    always_ff @(posedge CLK) begin
        if (accept) begin
            opnd  <= grant[1] ? REQ1_DATA : REQ0_DATA;
            cmd_r <= grant[1] ? REQ1_CMD  : REQ0_CMD;
            err_r <= cmd_illegal(grant[1] ? REQ1_CMD : REQ0_CMD);
            id_r  <= grant[1];
        end else if (state == EXEC) begin
            opnd <= ALU_RES;
        end
    end

    // Next-state and all outputs; outputs idle at 0 / NOP outside their state
    always_comb begin
        state_nx   = state;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        ALU_OPND   = '0;
        ALU_CMD    = CMD_W'(NOP);
        RSP_VALID  = 1'b0;
        RSP_DATA   = '0;
        RSP_ID     = 1'b0;
        RSP_ERR    = 1'b0;
        case (state)
            IDLE: begin
                REQ0_READY = grant[0];
                REQ1_READY = grant[1];
                if (accept) begin
                    state_nx = EXEC;
                end
            end
            EXEC: begin
                ALU_OPND = opnd;
                ALU_CMD  = err_r ? CMD_W'(NOP) : cmd_r;
                if (last_pass) begin
                    state_nx = RESP;
                end
            end
            RESP: begin
                RSP_VALID = 1'b1;
                RSP_DATA  = opnd;
                RSP_ID    = id_r;
                RSP_ERR   = err_r;
                if (RSP_READY) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

endmodule
